// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants and state encoding
// for the iterative multiply/divide sequencer.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic MD_MULT = 1'b0;
  localparam logic MD_DIV  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_ITER,
    ST_FIX,
    ST_DONE
  } md_state_t;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational shift-add (MULT)
// or restoring-divide (DIV) iteration on the accumulator.
import muldiv_pkg::*;

module muldiv_step #(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic               md_op,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem;
  logic [WIDTH:0] diff;

  // single iteration: add/shift-right or shift-left/trial-subtract
  always_comb begin
    sum  = {1'b0, acc[2*WIDTH-1:WIDTH]};
    if (acc[0])
      sum = sum + {1'b0, operand};
    rem  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff = rem - {1'b0, operand};
    if (md_op == MD_MULT)
      acc_nxt = {sum, acc[WIDTH-1:1]};
    else if (!diff[WIDTH])
      acc_nxt = {diff[WIDTH-1:0],
                 acc[WIDTH-2:0], 1'b1};
    else
      acc_nxt = {rem[WIDTH-1:0],
                 acc[WIDTH-2:0], 1'b0};
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: MULT/DIV FSM, counter, sign fix, HI/LO.
// Define MULDIV_SIGNED_EN for signed (MIPS) semantics.
import muldiv_pkg::*;

module muldiv_sequencer #(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             md_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  md_state_t          state, state_nxt;
  logic               op_q;
  logic               zdiv_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] acc_q, acc_nxt;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               sa, sb;
  logic [2*WIDTH-1:0] acc_neg;
  logic [WIDTH-1:0]   hi_fix, lo_fix;
  logic               iter_last;

  assign iter_last = (cnt_q == CW'(WIDTH - 1));

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .md_op   (op_q),
    .acc     (acc_q),
    .operand (opnd_q),
    .acc_nxt (acc_nxt)
  );

  // operand signs and magnitudes
  always_comb begin
`ifdef MULDIV_SIGNED_EN
    sa    = a_q[WIDTH-1];
    sb    = b_q[WIDTH-1];
    mag_a = sa ? (~a_q + 1'b1) : a_q;
    mag_b = sb ? (~b_q + 1'b1) : b_q;
`else
    sa    = 1'b0;
    sb    = 1'b0;
    mag_a = a_q;
    mag_b = b_q;
`endif
  end

  // final sign correction of product / quotient / remainder
  always_comb begin
    acc_neg = ~acc_q + 1'b1;
    if (op_q == MD_MULT) begin
      {hi_fix, lo_fix} = (sa ^ sb) ? acc_neg : acc_q;
    end else begin
      lo_fix = (sa ^ sb) ? acc_neg[WIDTH-1:0]
                         : acc_q[WIDTH-1:0];
      hi_fix = sa ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1)
                  : acc_q[2*WIDTH-1:WIDTH];
    end
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:
        if (start)
          state_nxt = (md_op == MD_DIV && op_b == '0)
                      ? ST_DONE : ST_PREP;
      ST_PREP: state_nxt = ST_ITER;
      ST_ITER: if (iter_last) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // handshake outputs
  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_DONE);
    div0 = done & zdiv_q;
  end

  // datapath: latch, prepare, iterate, write back
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= MD_MULT;
      zdiv_q <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      opnd_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      unique case (state)
        ST_IDLE:
          if (start) begin
            op_q   <= md_op;
            a_q    <= op_a;
            b_q    <= op_b;
            zdiv_q <= (md_op == MD_DIV) && (op_b == '0);
          end
        ST_PREP: begin
          cnt_q <= '0;
          if (op_q == MD_MULT) begin
            opnd_q <= mag_a;
            acc_q  <= {{WIDTH{1'b0}}, mag_b};
          end else begin
            opnd_q <= mag_b;
            acc_q  <= {{WIDTH{1'b0}}, mag_a};
          end
        end
        ST_ITER: begin
          acc_q <= acc_nxt;
          cnt_q <= cnt_q + CW'(1);
        end
        ST_FIX: begin
          hi_q <= hi_fix;
          lo_q <= lo_fix;
        end
        default: ;
      endcase
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: vector table plus scoreboard
// for the multiply/divide sequencer.
import muldiv_pkg::*;

module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        md_op;
  logic [31:0] op_a, op_b;
  logic        busy, done, div0;
  logic [31:0] hi, lo;

  muldiv_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .op_a  (op_a),
    .op_b  (op_b),
    .busy  (busy),
    .done  (done),
    .div0  (div0),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  typedef struct {
    logic [31:0] hi, lo;
    logic        div0;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk    = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  vec_t vecs[9];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // scoreboard: compare each done against queued result
  always @(negedge clk) begin
    if (!reset && done) begin
      exp_t e;
      done_cnt++;
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk("hi", {32'd0, hi}, {32'd0, e.hi});
        chk("lo", {32'd0, lo}, {32'd0, e.lo});
        chk("div0", {63'd0, div0}, {63'd0, e.div0});
      end
    end
  end

  task automatic do_op(input logic op,
                       input logic [31:0] a, b,
                       input logic [31:0] ehi, elo,
                       input logic ediv,
                       input int elat,
                       input bit pulse);
    int   n;
    bit   busy_bad;
    exp_t e;
    @(negedge clk);
    chk("idle_before", {63'd0, busy}, 64'd0);
    start = 1'b1; md_op = op; op_a = a; op_b = b;
    e.hi = ehi; e.lo = elo; e.div0 = ediv;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    op_a = $urandom; op_b = $urandom;
    n = 1;
    busy_bad = 1'b0;
    while (!done && n < 100) begin
      if (!busy) busy_bad = 1'b1;
      start = pulse && (n == 10);
      md_op = MD_DIV; op_b = 32'd0;
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(n), 64'(elat));
    chk("busy_window", {63'd0, busy_bad}, 64'd0);
    if (pulse) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("idle_after", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int dc;
    vecs[0] = '{MD_MULT, 32'd7, 32'd6, 32'h0, 32'h2A};
    vecs[1] = '{MD_DIV, 32'd100, 32'd7, 32'd2, 32'd14};
`ifdef MULDIV_SIGNED_EN
    vecs[2] = '{MD_MULT, 32'hFFFFFFFD, 32'd5,
                32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[3] = '{MD_DIV, 32'hFFFFFFF9, 32'd2,
                32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4] = '{MD_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF,
                32'h0, 32'h1};
    vecs[5] = '{MD_DIV, 32'h80000000, 32'hFFFFFFFF,
                32'h0, 32'h80000000};
    vecs[6] = '{MD_DIV, 32'd7, 32'hFFFFFFFE,
                32'd1, 32'hFFFFFFFD};
    vecs[7] = '{MD_MULT, 32'h80000000, 32'd2,
                32'hFFFFFFFF, 32'h0};
`else
    vecs[2] = '{MD_MULT, 32'hFFFFFFFD, 32'd5,
                32'h4, 32'hFFFFFFF1};
    vecs[3] = '{MD_DIV, 32'hFFFFFFF9, 32'd2,
                32'd1, 32'h7FFFFFFC};
    vecs[4] = '{MD_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF,
                32'hFFFFFFFE, 32'h1};
    vecs[5] = '{MD_DIV, 32'h80000000, 32'hFFFFFFFF,
                32'h80000000, 32'h0};
    vecs[6] = '{MD_DIV, 32'd7, 32'hFFFFFFFE,
                32'd7, 32'h0};
    vecs[7] = '{MD_MULT, 32'h80000000, 32'd2,
                32'h1, 32'h0};
`endif
    vecs[8] = '{MD_DIV, 32'h2211, 32'h100,
                32'h11, 32'h22};

    reset = 1'b1; start = 1'b0; md_op = MD_MULT;
    op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_div0", {63'd0, div0}, 64'd0);
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    reset = 1'b0;

    foreach (vecs[i])
      do_op(vecs[i].op, vecs[i].a, vecs[i].b,
            vecs[i].hi, vecs[i].lo, 1'b0, 35, 1'b0);

    // divide by zero keeps preloaded 0x11/0x22
    do_op(MD_DIV, 32'd1234, 32'd0,
          32'h11, 32'h22, 1'b1, 1, 1'b0);
    chk("div0_hi_kept", {32'd0, hi}, 64'h11);
    chk("div0_lo_kept", {32'd0, lo}, 64'h22);

    // extra start pulses during a running MULT
    dc = done_cnt;
    do_op(MD_MULT, 32'h10001, 32'h30003,
          32'h3, 32'h00060003, 1'b0, 35, 1'b1);
    repeat (40) @(negedge clk);
    chk("one_done", 64'(done_cnt - dc), 64'd1);
    chk("pulse_hi", {32'd0, hi}, 64'h3);
    chk("pulse_lo", {32'd0, lo}, 64'h00060003);

    // reset in the middle of ITER
    dc = done_cnt;
    @(negedge clk);
    start = 1'b1; md_op = MD_MULT;
    op_a = 32'h1234; op_b = 32'h10;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (13) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_done", {63'd0, done}, 64'd0);
    chk("mid_rst_hi", {32'd0, hi}, 64'd0);
    chk("mid_rst_lo", {32'd0, lo}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("no_done_after_rst", 64'(done_cnt - dc), 64'd0);

    do_op(MD_MULT, 32'd2, 32'd3,
          32'h0, 32'h6, 1'b0, 35, 1'b0);
    repeat (2) @(negedge clk);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
